instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer_pkg.sv | 23 ++
 rtl/instr_fetch_buffer_if.sv | 20 ++
 rtl/instr_fetch_buffer_sync_fifo.sv | 45 ++++
 rtl/instr_fetch_buffer.sv | 93 +++++++++
 tb/tb_instr_fetch_buffer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared core definitions: data width, default reset PC and the instruction
// field positions used by the fetch buffer to pre-slice decode fields.
package osiris_i;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OP_HI         = 6;
    localparam int OP_LO         = 2;
    localparam int FUNCT_3_HI    = 14;
    localparam int FUNCT_3_LO    = 12;
    localparam int FUNCT_7_5_BIT = 30;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Push/pop bundle between the fetch control logic and its entry FIFO.
interface instr_fetch_buffer_if #(
    parameter int WIDTH = 64,
    parameter int CW    = 3
);
    // Handshake: an entry is written on any cycle with push high (master only
    // pushes when !full or when popping the same cycle); the head is consumed
    // on any cycle with pop high and empty low; head is valid whenever !empty.
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

    modport master (output push, push_data, pop, input head, full, empty, count);
    modport slave  (input push, push_data, pop, output head, full, empty, count);

endinterface

// File: rtl/instr_fetch_buffer_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; push and pop may coincide at any
// occupancy, including full, because the head is read before the slot is reused.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    instr_fetch_buffer_if.slave  fifo
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign fifo.empty = (count == '0);
    assign fifo.full  = (count == CW'(DEPTH));
    assign fifo.count = count;
    assign fifo.head  = mem[rd_ptr];
    assign do_pop     = fifo.pop && !fifo.empty;
    assign do_push    = fifo.push;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= fifo.push_data;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: credit-limited request issue, in-order response
// capture into a FIFO, and redirect handling that discards stale responses.
module instr_fetch_buffer
    import osiris_i::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_op,
    output logic [2:0]      o_funct_3,
    output logic            o_funct_7_5
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [SW-1:0]   in_flight;
    logic            fire;
    logic            rv_drop;
    logic            rv_keep;
    logic            pop;
    fetch_entry_t    head;

    instr_fetch_buffer_if #(.WIDTH($bits(fetch_entry_t)), .CW(CW)) fifo_bus ();

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (i_redirect),
        .fifo  (fifo_bus.slave)
    );

    // Every granted fetch owns a FIFO slot until popped, so the sum never exceeds DEPTH.
    assign in_flight  = SW'(fifo_bus.count) + SW'(outstanding) + SW'(discard);
    assign o_imem_req = !i_rst && (in_flight < SW'(DEPTH));
    assign o_imem_addr = fetch_pc;
    assign fire       = o_imem_req && i_imem_gnt;

    // Responses to pre-redirect requests are consumed first; a stray rvalid
    // with nothing in flight matches neither term and is ignored.
    assign rv_drop = i_imem_rvalid && (discard != '0);
    assign rv_keep = i_imem_rvalid && (discard == '0) && (outstanding != '0);

    assign o_instr_valid      = !fifo_bus.empty && !i_rst;
    assign pop                = o_instr_valid && i_instr_ready && !i_redirect;
    assign fifo_bus.pop       = pop;
    assign fifo_bus.push      = rv_keep && !i_redirect && (!fifo_bus.full || pop);
    assign fifo_bus.push_data = {resp_pc, i_imem_rdata};

    assign head        = fifo_bus.head;
    assign o_instr     = head.instr;
    assign o_pc        = head.pc;
    assign o_op        = head.instr[OP_HI:OP_LO];
    assign o_funct_3   = head.instr[FUNCT_3_HI:FUNCT_3_LO];
    assign o_funct_7_5 = head.instr[FUNCT_7_5_BIT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (i_redirect) begin
            // Everything still owed by memory, including this cycle's grant, becomes stale.
            fetch_pc    <= align_word(i_redirect_pc);
            resp_pc     <= align_word(i_redirect_pc);
            outstanding <= '0;
            discard     <= discard + outstanding + CW'(fire) - CW'(rv_drop) - CW'(rv_keep);
        end else begin
            if (fire)    fetch_pc <= fetch_pc + 32'd4;
            if (rv_keep) resp_pc  <= resp_pc + 32'd4;
            outstanding <= outstanding + CW'(fire) - CW'(rv_keep);
            discard     <= discard - CW'(rv_drop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios plus random traffic, checked
// against a queue-level model of granted fetches and buffered instructions.
module tb_instr_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [4:0]  o_op;
    logic [2:0]  o_funct_3;
    logic        o_funct_7_5;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_op          (o_op),
        .o_funct_3     (o_funct_3),
        .o_funct_7_5   (o_funct_7_5)
    );

    always #5 i_clk = ~i_clk;

    // Granted fetches awaiting a response; stale ones were overtaken by a redirect.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch = RESET_PC;
    int          errors = 0;
    int          checks = 0;
    int          grant_cnt = 0;
    int          pop_cnt = 0;
    bit          want_first = 0;
    logic [31:0] first_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        exp_req;
        logic        exp_valid;
        logic [63:0] h;
        exp_req   = !i_rst && ((exp_q.size() + pend_q.size()) < DEPTH);
        exp_valid = !i_rst && (exp_q.size() != 0);
        chk("imem_req", 32'(o_imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", o_imem_addr, exp_fetch);
        chk("instr_valid", 32'(o_instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            h = exp_q[0];
            chk("pc", o_pc, h[63:32]);
            chk("instr", o_instr, h[31:0]);
            chk("op", 32'(o_op), 32'(h[6:2]));
            chk("funct_3", 32'(o_funct_3), 32'(h[14:12]));
            chk("funct_7_5", 32'(o_funct_7_5), 32'(h[30]));
        end
        if (want_first && o_instr_valid) begin
            chk("first_pc_after_jump", o_pc, first_pc);
            want_first = 0;
        end
        if (o_imem_req && i_imem_gnt) grant_cnt++;
        if (o_instr_valid && i_instr_ready) pop_cnt++;
    endtask

    task automatic model_update();
        logic  exp_req;
        pend_t e;
        if (i_rst) begin
            exp_q.delete();
            pend_q.delete();
            exp_fetch = RESET_PC;
            return;
        end
        exp_req = (exp_q.size() + pend_q.size()) < DEPTH;
        if ((exp_q.size() != 0) && i_instr_ready && !i_redirect) void'(exp_q.pop_front());
        if (i_imem_rvalid && (pend_q.size() != 0)) begin
            e = pend_q.pop_front();
            if (!e.stale && !i_redirect) exp_q.push_back({e.addr, mem_word(e.addr)});
        end
        if (exp_req && i_imem_gnt) begin
            pend_q.push_back('{addr: exp_fetch, stale: i_redirect});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (i_redirect) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            exp_fetch = {i_redirect_pc[31:2], 2'b00};
        end
    endtask

    // rv_mode: 0 none, 1 answer oldest pending, 2 random answer, 3 unsolicited rvalid.
    task automatic step(input bit rst_v, input bit gnt_v, input bit ready_v, input bit redir_v,
                        input logic [31:0] rpc, input int rv_mode);
        bit rv;
        case (rv_mode)
            1:       rv = (pend_q.size() != 0);
            2:       rv = (pend_q.size() != 0) && ($urandom_range(0, 3) != 0);
            3:       rv = 1'b1;
            default: rv = 1'b0;
        endcase
        i_rst         = rst_v;
        i_imem_gnt    = gnt_v;
        i_instr_ready = ready_v;
        i_redirect    = redir_v;
        i_redirect_pc = rpc;
        i_imem_rvalid = rv;
        i_imem_rdata  = (rv && (pend_q.size() != 0)) ? mem_word(pend_q[0].addr) : $urandom();
        #1;
        check_outputs();
        model_update();
        @(negedge i_clk);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 0, '0, 1);
    endtask

    initial begin
        i_rst = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b0;
        @(negedge i_clk);

        // Reset held, then streaming at full rate.
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0, '0, 1);
        pop_cnt = 0;
        want_first = 1; first_pc = RESET_PC;
        for (int k = 0; k < 20; k++) step(0, 1, 1, 0, '0, 1);
        chk("throughput_pops", pop_cnt, 18);

        // Decode stalled: only DEPTH grants, then drain in order.
        drain(6);
        grant_cnt = 0;
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, '0, 1);
        chk("stall_grants", grant_cnt, DEPTH);
        chk("stall_req_low", 32'(o_imem_req), 32'd0);
        pop_cnt = 0;
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, '0, 1);
        chk("stall_pops", pop_cnt, 4);
        chk("req_resumes", 32'(o_imem_req), 32'd1);

        // Redirect with three fetches outstanding.
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, '0, 0);
        want_first = 1; first_pc = 32'h0000_0100;
        step(0, 0, 1, 1, 32'h0000_0100, 0);
        for (int k = 0; k < 15; k++) step(0, 1, 1, 0, '0, 1);

        // Unaligned redirect target and address wrap.
        drain(6);
        step(0, 0, 1, 1, 32'h0000_0103, 0);
        chk("aligned_target", o_imem_addr, 32'h0000_0100);
        step(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
        want_first = 1; first_pc = 32'hFFFF_FFFC;
        step(0, 1, 1, 0, '0, 1);
        chk("addr_wrap", o_imem_addr, 32'h0000_0000);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0, '0, 1);

        // Redirect coinciding with a grant and a response.
        drain(6);
        for (int k = 0; k < 2; k++) step(0, 1, 1, 0, '0, 0);
        want_first = 1; first_pc = 32'h0000_0200;
        step(0, 1, 1, 1, 32'h0000_0200, 1);
        for (int k = 0; k < 15; k++) step(0, 1, 1, 0, '0, 1);

        // Reset mid-flight with late responses arriving during and after it.
        drain(6);
        for (int k = 0; k < 2; k++) step(0, 1, 1, 0, '0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0, '0, 3);
        step(0, 0, 1, 0, '0, 3);
        chk("restart_addr", o_imem_addr, RESET_PC);
        step(0, 0, 1, 0, '0, 3);
        want_first = 1; first_pc = RESET_PC;
        for (int k = 0; k < 10; k++) step(0, 1, 1, 0, '0, 1);

        // Random traffic with redirects, some near the top of the address space.
        for (int k = 0; k < 400; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom();
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, tgt, 2);
        end
        drain(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
